// File: rtl/mips_hazard_scoreboard.sv
// Hazard scoreboard for the pipelined MIPS core: tracks in-flight register writes
// for DEPTH stages after ID and decides stall/issue plus per-operand forward source.
module mips_hazard_scoreboard #(
  parameter int REG_AW     = 5,
  parameter int DEPTH      = 3,
  parameter int LOAD_STAGE = 2,
  parameter int FORWARD    = 1,
  parameter int CNT_W      = 16,
  localparam int SEL_W     = $clog2(DEPTH + 1)
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              id_valid,
  input  logic [REG_AW-1:0] id_rs,
  input  logic [REG_AW-1:0] id_rt,
  input  logic              id_use_rs,
  input  logic              id_use_rt,
  input  logic [REG_AW-1:0] id_dest,
  input  logic              id_write,
  input  logic              id_load,
  input  logic              id_flush,
  output logic              stall,
  output logic              issue,
  output logic [SEL_W-1:0]  fwd_rs,
  output logic [SEL_W-1:0]  fwd_rt,
  output logic [CNT_W-1:0]  stall_count
);

  localparam logic [SEL_W-1:0] LS_SEL = SEL_W'(LOAD_STAGE);

  // Index 0 holds stage 1 (EX), index DEPTH-1 holds stage DEPTH (WB).
  logic [DEPTH-1:0]             vld_q, vld_d;
  logic [DEPTH-1:0][REG_AW-1:0] dst_q, dst_d;
  logic [DEPTH-1:0]             ld_q,  ld_d;
  logic [CNT_W-1:0]             cnt_q, cnt_d;

  logic [SEL_W-1:0] rs_sel, rt_sel;
  logic             rs_ld, rt_ld;
  logic             rs_rdy, rt_rdy;
  logic             stall_w, issue_w;

  // Scan oldest to youngest so the lowest matching stage overwrites older hits.
  always_comb begin
    rs_sel = '0;
    rs_ld  = 1'b0;
    rt_sel = '0;
    rt_ld  = 1'b0;
    for (int k = DEPTH; k >= 1; k--) begin
      if (id_use_rs && (id_rs != '0) && vld_q[k-1] && (dst_q[k-1] == id_rs)) begin
        rs_sel = SEL_W'(k);
        rs_ld  = ld_q[k-1];
      end
      if (id_use_rt && (id_rt != '0) && vld_q[k-1] && (dst_q[k-1] == id_rt)) begin
        rt_sel = SEL_W'(k);
        rt_ld  = ld_q[k-1];
      end
    end
  end

  always_comb begin
    rs_rdy = 1'b1;
    rt_rdy = 1'b1;
    fwd_rs = '0;
    fwd_rt = '0;
    if (FORWARD != 0) begin
      // A load result only exists from LOAD_STAGE onwards.
      rs_rdy = (rs_sel == '0) || !rs_ld || (rs_sel >= LS_SEL);
      rt_rdy = (rt_sel == '0) || !rt_ld || (rt_sel >= LS_SEL);
      fwd_rs = rs_sel;
      fwd_rt = rt_sel;
    end else begin
      rs_rdy = (rs_sel == '0);
      rt_rdy = (rt_sel == '0);
    end
  end

  // Flush wins: a killed instruction neither stalls nor issues.
  assign stall_w = id_valid && !id_flush && !(rs_rdy && rt_rdy);
  assign issue_w = id_valid && !id_flush && !stall_w;

  assign stall       = stall_w;
  assign issue       = issue_w;
  assign stall_count = cnt_q;

  always_comb begin
    vld_d = {vld_q[DEPTH-2:0], issue_w && id_write && (id_dest != '0)};
    dst_d = {dst_q[DEPTH-2:0], id_dest};
    ld_d  = {ld_q[DEPTH-2:0], id_load};
    cnt_d = cnt_q;
    if (stall_w && (cnt_q != {CNT_W{1'b1}})) begin
      cnt_d = cnt_q + CNT_W'(1);
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      vld_q <= '0;
      dst_q <= '0;
      ld_q  <= '0;
      cnt_q <= '0;
    end else begin
      vld_q <= vld_d;
      dst_q <= dst_d;
      ld_q  <= ld_d;
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: tb/tb_mips_hazard_scoreboard.sv
// Bench for mips_hazard_scoreboard: three parameterisations share one ID stream and
// are compared against a queue-of-writes reference model, plus directed scenarios.
module tb_mips_hazard_scoreboard;

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       id_valid = 1'b0;
  logic [4:0] id_rs = '0, id_rt = '0, id_dest = '0;
  logic       id_use_rs = 1'b0, id_use_rt = 1'b0;
  logic       id_write = 1'b0, id_load = 1'b0, id_flush = 1'b0;

  // Instance 0: forwarding, DEPTH 3, LOAD_STAGE 2.
  // Instance 1: stall-only, DEPTH 3.
  // Instance 2: stall-only, DEPTH 5, LOAD_STAGE 4, 2-bit counter.
  logic        stall0, issue0, stall1, issue1, stall2, issue2;
  logic [1:0]  frs0, frt0, frs1, frt1;
  logic [2:0]  frs2, frt2;
  logic [15:0] cnt0, cnt1;
  logic [1:0]  cnt2;

  always #5 clk = ~clk;

  mips_hazard_scoreboard u_fwd (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest), .id_write(id_write),
    .id_load(id_load), .id_flush(id_flush), .stall(stall0), .issue(issue0),
    .fwd_rs(frs0), .fwd_rt(frt0), .stall_count(cnt0));

  mips_hazard_scoreboard #(.FORWARD(0)) u_nofwd (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest), .id_write(id_write),
    .id_load(id_load), .id_flush(id_flush), .stall(stall1), .issue(issue1),
    .fwd_rs(frs1), .fwd_rt(frt1), .stall_count(cnt1));

  mips_hazard_scoreboard #(.DEPTH(5), .LOAD_STAGE(4), .FORWARD(0), .CNT_W(2)) u_sat (
    .clk(clk), .reset(reset), .id_valid(id_valid), .id_rs(id_rs), .id_rt(id_rt),
    .id_use_rs(id_use_rs), .id_use_rt(id_use_rt), .id_dest(id_dest), .id_write(id_write),
    .id_load(id_load), .id_flush(id_flush), .stall(stall2), .issue(issue2),
    .fwd_rs(frs2), .fwd_rt(frt2), .stall_count(cnt2));

  // Reference model: a flat list of in-flight writes, each with its age in stages.
  typedef struct {
    int         inst;
    logic [4:0] dest;
    logic       load;
    int         age;
  } wr_t;

  wr_t fl_q[$];
  int  p_depth[3] = '{3, 3, 5};
  int  p_ls[3]    = '{2, 2, 4};
  int  p_fwd[3]   = '{1, 0, 0};
  int  p_cmax[3]  = '{65535, 65535, 3};
  int  m_cnt[3];
  bit  e_stall[3], e_issue[3];
  int  e_frs[3], e_frt[3];
  int  s_stall[3], s_issue[3], s_frs[3], s_frt[3], s_cnt[3];

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check_eq(input string tag, input longint got, input longint exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
    end
  endtask

  function automatic void src_eval(input int inst, input logic use_s, input logic [4:0] r,
                                   output bit ready, output int sel);
    int  best_age;
    bit  best_load;
    best_age  = 0;
    best_load = 1'b0;
    ready     = 1'b1;
    sel       = 0;
    if (use_s && r != 5'd0) begin
      foreach (fl_q[j]) begin
        if (fl_q[j].inst == inst && fl_q[j].dest == r &&
            (best_age == 0 || fl_q[j].age < best_age)) begin
          best_age  = fl_q[j].age;
          best_load = fl_q[j].load;
        end
      end
      if (best_age != 0) begin
        if (p_fwd[inst] == 0) begin
          ready = 1'b0;
        end else begin
          sel   = best_age;
          ready = !best_load || (best_age >= p_ls[inst]);
        end
      end
    end
  endfunction

  function automatic void model_eval();
    bit rdy_s, rdy_t;
    for (int i = 0; i < 3; i++) begin
      src_eval(i, id_use_rs, id_rs, rdy_s, e_frs[i]);
      src_eval(i, id_use_rt, id_rt, rdy_t, e_frt[i]);
      e_stall[i] = id_valid && !id_flush && !(rdy_s && rdy_t);
      e_issue[i] = id_valid && !id_flush && !e_stall[i];
    end
  endfunction

  function automatic void model_step();
    wr_t w;
    for (int j = fl_q.size() - 1; j >= 0; j--) begin
      fl_q[j].age = fl_q[j].age + 1;
      if (fl_q[j].age > p_depth[fl_q[j].inst]) fl_q.delete(j);
    end
    for (int i = 0; i < 3; i++) begin
      if (e_issue[i] && id_write && id_dest != 5'd0) begin
        w.inst = i;
        w.dest = id_dest;
        w.load = id_load;
        w.age  = 1;
        fl_q.push_back(w);
      end
      if (e_stall[i] && m_cnt[i] < p_cmax[i]) m_cnt[i]++;
    end
  endfunction

  function automatic void model_clear();
    fl_q.delete();
    for (int i = 0; i < 3; i++) m_cnt[i] = 0;
  endfunction

  task automatic sample_dut();
    s_stall = '{int'(stall0), int'(stall1), int'(stall2)};
    s_issue = '{int'(issue0), int'(issue1), int'(issue2)};
    s_frs   = '{int'(frs0), int'(frs1), int'(frs2)};
    s_frt   = '{int'(frt0), int'(frt1), int'(frt2)};
    s_cnt   = '{int'(cnt0), int'(cnt1), int'(cnt2)};
  endtask

  // One ID cycle: drive on the falling edge, compare before the rising edge, then advance the model.
  task automatic drive(input logic v, input logic [4:0] rs, input logic [4:0] rt,
                       input logic urs, input logic urt, input logic [4:0] dest,
                       input logic wr, input logic ld, input logic fl);
    @(negedge clk);
    id_valid = v;  id_rs = rs;  id_rt = rt;  id_use_rs = urs;  id_use_rt = urt;
    id_dest = dest;  id_write = wr;  id_load = ld;  id_flush = fl;
    #1;
    model_eval();
    sample_dut();
    for (int i = 0; i < 3; i++) begin
      check_eq($sformatf("stall[%0d]", i), s_stall[i], e_stall[i]);
      check_eq($sformatf("issue[%0d]", i), s_issue[i], e_issue[i]);
      check_eq($sformatf("stall_count[%0d]", i), s_cnt[i], m_cnt[i]);
      if (e_issue[i]) begin
        check_eq($sformatf("fwd_rs[%0d]", i), s_frs[i], e_frs[i]);
        check_eq($sformatf("fwd_rt[%0d]", i), s_frt[i], e_frt[i]);
      end
    end
    @(posedge clk);
    model_step();
  endtask

  task automatic do_reset(input bit expect_stall1);
    @(negedge clk);
    #2;
    if (expect_stall1) check_eq("pre_reset_stall1", stall1, 1);
    reset = 1'b1;
    #1;
    model_clear();
    check_eq("rst_stall0", stall0, 0);
    check_eq("rst_stall1", stall1, 0);
    check_eq("rst_stall2", stall2, 0);
    check_eq("rst_cnt0", cnt0, 0);
    check_eq("rst_cnt1", cnt1, 0);
    check_eq("rst_cnt2", cnt2, 0);
    id_valid = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  initial begin
    reset = 1'b1;
    #12;
    reset = 1'b0;
    model_clear();

    // ALU-to-use: ADDI R1,R0,10 then ADD R4,R1,R1, held until every instance issues.
    do_reset(1'b0);
    drive(1, 5'd0, 5'd0, 1, 0, 5'd1, 1, 0, 0);
    for (int c = 0; c < 6; c++) begin
      drive(1, 5'd1, 5'd1, 1, 1, 5'd4, 1, 0, 0);
      if (c == 0) begin
        check_eq("alu_use_issue0", s_issue[0], 1);
        check_eq("alu_use_frs0", s_frs[0], 1);
        check_eq("alu_use_frt0", s_frt[0], 1);
      end
      if (c < 3) check_eq("nofwd_stall1", s_stall[1], 1);
      if (c == 3) begin
        check_eq("nofwd_issue1", s_issue[1], 1);
        check_eq("nofwd_frs1", s_frs[1], 0);
      end
      if (c < 5) check_eq("sat_stall2", s_stall[2], 1);
    end
    #1;
    check_eq("nofwd_count1", cnt1, 3);
    check_eq("sat_count2", cnt2, 3);

    // Load-to-use: LW R2 then SLT R5,R2,R3.
    do_reset(1'b0);
    drive(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0);
    drive(1, 5'd2, 5'd3, 1, 1, 5'd5, 1, 0, 0);
    check_eq("load_use_stall0", s_stall[0], 1);
    drive(1, 5'd2, 5'd3, 1, 1, 5'd5, 1, 0, 0);
    check_eq("load_use_issue0", s_issue[0], 1);
    check_eq("load_use_frs0", s_frs[0], 2);
    check_eq("load_use_frt0", s_frt[0], 0);

    // Youngest match wins; writes to R0 never create a hazard.
    do_reset(1'b0);
    drive(1, 5'd0, 5'd0, 1, 0, 5'd3, 1, 0, 0);
    drive(1, 5'd0, 5'd0, 1, 0, 5'd3, 1, 0, 0);
    drive(1, 5'd3, 5'd0, 1, 1, 5'd6, 1, 0, 0);
    check_eq("youngest_frs0", s_frs[0], 1);
    drive(1, 5'd0, 5'd0, 1, 0, 5'd0, 1, 0, 0);
    drive(1, 5'd0, 5'd0, 1, 1, 5'd7, 1, 0, 0);
    check_eq("r0_stall0", s_stall[0], 0);
    check_eq("r0_stall1", s_stall[1], 0);
    check_eq("r0_stall2", s_stall[2], 0);

    // Flush during a load-use stall inserts a bubble even though the victim writes R2.
    do_reset(1'b0);
    drive(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0);
    drive(1, 5'd2, 5'd3, 1, 1, 5'd2, 1, 0, 0);
    drive(1, 5'd2, 5'd3, 1, 1, 5'd2, 1, 0, 1);
    check_eq("flush_stall0", s_stall[0], 0);
    check_eq("flush_issue0", s_issue[0], 0);
    drive(1, 5'd2, 5'd3, 1, 1, 5'd9, 1, 0, 0);
    check_eq("post_flush_frs0", s_frs[0], 3);

    // Reset asserted in the middle of a stall.
    do_reset(1'b0);
    drive(1, 5'd1, 5'd0, 1, 0, 5'd2, 1, 1, 0);
    drive(1, 5'd2, 5'd3, 1, 1, 5'd5, 1, 0, 0);
    do_reset(1'b1);

    // Random instruction stream over a small register window to provoke hazards.
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset(1'b0);
      drive($urandom_range(0, 99) < 85,
            5'($urandom_range(0, 7)), 5'($urandom_range(0, 7)),
            $urandom_range(0, 99) < 80, $urandom_range(0, 99) < 60,
            5'($urandom_range(0, 7)),
            $urandom_range(0, 99) < 70, $urandom_range(0, 99) < 30,
            $urandom_range(0, 99) < 8);
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/mips_hazard_scoreboard.md
# mips_hazard_scoreboard

Parametrised hazard-detection and forwarding-select unit for the pipelined MIPS core, replacing the hand-inserted NOPs the single-cycle programs need today. It sits beside the ID stage and tracks every in-flight register write in a DEPTH-entry shift scoreboard. Each cycle it decides whether the instruction in ID may issue, or must stall with a bubble, and which pipeline stage each source operand must be forwarded from. Forwarding can be disabled by parameter, giving a stall-only mode for bring-up.

## Interface
Parameters:
- REG_AW, 5, register address width.
- DEPTH, 3, tracked stages after ID (stage 1 = EX … stage DEPTH = WB); legal range 2..7.
- LOAD_STAGE, 2, first stage index at which a load result is forwardable; legal range 1..DEPTH.
- FORWARD, 1, 1 = forwarding enabled, 0 = stall-only mode.
- CNT_W, 16, stall counter width.
- SEL_W (localparam), $clog2(DEPTH+1).

Ports:
- clk, in, 1, core clock.
- reset, in, 1, asynchronous, active-high; clears the scoreboard.
- id_valid, in, 1, ID holds a real instruction.
- id_rs, in, REG_AW, ID source register rs.
- id_rt, in, REG_AW, ID source register rt.
- id_use_rs, in, 1, instruction reads rs.
- id_use_rt, in, 1, instruction reads rt.
- id_dest, in, REG_AW, ID destination register.
- id_write, in, 1, instruction writes id_dest.
- id_load, in, 1, instruction is a load.
- id_flush, in, 1, kill the ID instruction (branch taken).
- stall, out, 1, hold PC/IF/ID this cycle.
- issue, out, 1, ID instruction advances to stage 1 at this edge.
- fwd_rs, out, SEL_W, rs source: 0 = register file, k = stage k.
- fwd_rt, out, SEL_W, rt source, same encoding.
- stall_count, out, CNT_W, saturating count of stalled cycles.

## Operation
- Scoreboard entry per stage k: valid, dest, load. All entries shift k→k+1 every clock. The entry in stage DEPTH drops out.
- Stage 1 loads {issue & id_write & (id_dest!=0), id_dest, id_load}. It loads a bubble (valid=0) when stall, id_flush, or !id_valid.
- A source matches stage k when it is used, is nonzero, and equals a valid dest in stage k. R0 never matches.
- Youngest-match rule: for each source, the lowest matching k wins. Older matches are ignored.
- FORWARD=1:
  - A source is ready if it has no match, or if its youngest match is a non-load, or a load with k ≥ LOAD_STAGE.
  - fwd_x = youngest matching k when there is a match, else 0.
- FORWARD=0: a source is ready only when it has no match in any stage. fwd_x is always 0.
- stall = id_valid & !id_flush & !(rs ready & rt ready).
- issue = id_valid & !id_flush & !stall.
- fwd_rs and fwd_rt are combinational. They are valid whenever issue=1 and are don't-care otherwise; the bench checks them only on issue.
- stall_count increments on every clock with stall=1. It saturates at 2^CNT_W−1.
- id_flush has priority over stall: no stall, no issue, bubble enters stage 1.

## Timing
- stall, issue and fwd_* are combinational from the ID inputs and the scoreboard state. The scoreboard itself is registered.
- Stall latency:
  - ALU-to-use with FORWARD=1: 0 stall cycles.
  - Load-to-use: LOAD_STAGE−1 stall cycles.
  - Any RAW hazard with FORWARD=0: DEPTH stall cycles, then issue with fwd=0.
- While stall=1, the ID inputs are held by the core and re-evaluated each cycle. A bubble enters stage 1 on each stalled cycle.
- Reset (asynchronous, any time, including mid-stall):
  - All entry valids go to 0 and stall_count goes to 0 immediately.
  - Consequently stall=0 and fwd_*=0 for any ID instruction until new entries are issued.
- A producer and a consumer in the same ID slot never conflict: the ID instruction is checked only against stages 1..DEPTH, never against itself.

## Test plan
- Reset, then ADDI R1,R0,10 followed immediately by ADD R4,R1,R1 (FORWARD=1) → no stall; on the consumer's issue fwd_rs=1 and fwd_rt=1.
- Same sequence with FORWARD=0, DEPTH=3 → stall high for exactly 3 cycles, then issue with fwd_rs=0; stall_count=3.
- LW R2 followed immediately by SLT R5,R2,R3, LOAD_STAGE=2 → 1 stall cycle, then issue with fwd_rs=2, fwd_rt=0.
- ADDI R3 at t, ADDI R3 at t+1, ADD R6,R3,R0 at t+2 → fwd_rs=1 (youngest, not 2); writes to R0 never raise stall.
- Load-use stall with id_flush asserted in the stall cycle → stall=0 and issue=0; the next cycle has stage 1 valid=0.
- Assert reset mid-stall → stall drops asynchronously and stall_count=0. Separately, with CNT_W=2, hold a hazard for 5 cycles → stall_count saturates at 3.
